// File: rtl/root_square_check_pkg.sv
// ----------------------------------------------------------------------------
// root_square_check_pkg
// Shared types for the square-root result checker of the MDR system.
//   MDR_DW           : default root operand width
//   DW2              : squared-value width (2*MDR_DW)
//   data_t           : 2*DW-wide value (reminder, rebuilt square)
//   data_in_t        : DW-wide value (root, original operand)
//   root_chk_cnt_t   : multiply step counter
//   root_chk_state_t : checker FSM states
// ----------------------------------------------------------------------------
package root_square_check_pkg;

    localparam int unsigned MDR_DW = 16;
    localparam int unsigned DW2    = 2 * MDR_DW;

    typedef logic [DW2-1:0]             data_t;
    typedef logic [MDR_DW-1:0]          data_in_t;
    typedef logic [$clog2(MDR_DW)-1:0]  root_chk_cnt_t;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        ADD,
        DONE
    } root_chk_state_t;

endpackage

// File: rtl/root_square_check_if.sv
// ----------------------------------------------------------------------------
// root_square_check_if
// Request/result bundle of the root/reminder checker.
//   i_start     : one-cycle request, sampled only while the checker is idle
//   i_root      : root (quotient) to check
//   i_reminder  : reminder paired with i_root
//   i_val_x     : original operand
//   o_busy      : checker occupied
//   o_done      : one-cycle result strobe
//   o_value     : rebuilt root*root + reminder (low 2*DW bits)
//   o_match     : rebuilt value equals x (no overflow, bound ok)
//   o_overflow  : carry out of the final add
//   o_bound_err : reminder exceeds 2*root (bound build only)
// Modports: master drives requests, slave (the checker) drives results.
// ----------------------------------------------------------------------------
interface root_square_check_if
    import root_square_check_pkg::*;
#(
    parameter int unsigned DW = MDR_DW
);

    logic              i_start;
    logic [DW-1:0]     i_root;
    logic [2*DW-1:0]   i_reminder;
    logic [DW-1:0]     i_val_x;
    logic              o_busy;
    logic              o_done;
    logic [2*DW-1:0]   o_value;
    logic              o_match;
    logic              o_overflow;
    logic              o_bound_err;

    modport master (
        output i_start, i_root, i_reminder, i_val_x,
        input  o_busy, o_done, o_value, o_match, o_overflow, o_bound_err
    );

    modport slave (
        input  i_start, i_root, i_reminder, i_val_x,
        output o_busy, o_done, o_value, o_match, o_overflow, o_bound_err
    );

endinterface

// File: rtl/root_square_check_seq_squarer.sv
// ----------------------------------------------------------------------------
// root_square_check_seq_squarer
// Shift-add squarer: one partial product per step, then a single addend add.
//   clk, rst   : clock, synchronous active-high reset
//   load       : capture root as multiplicand/multiplier, clear acc/counter
//   step       : one shift-add iteration
//   add_rem    : acc += addend
//   root       : operand to square
//   addend     : value added after the last step (reminder)
//   acc        : 2*DW+1 bit accumulator
//   last_step  : current step is the final one (counter == DW-1)
// ----------------------------------------------------------------------------
module root_square_check_seq_squarer
    import root_square_check_pkg::*;
#(
    parameter int unsigned DW = MDR_DW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic             add_rem,
    input  logic [DW-1:0]    root,
    input  logic [2*DW-1:0]  addend,
    output logic [2*DW:0]    acc,
    output logic             last_step
);

    localparam int unsigned CW = (DW > 1) ? $clog2(DW) : 1;

    logic [2*DW-1:0] mcand;
    logic [DW-1:0]   mplier;
    logic [CW-1:0]   cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
        end else if (load) begin
            mcand  <= {{DW{1'b0}}, root};
            mplier <= root;
            acc    <= '0;
            cnt    <= '0;
        end else if (step) begin
            if (mplier[0]) begin
                acc <= acc + {1'b0, mcand};
            end
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CW'(1);
        end else if (add_rem) begin
            acc <= acc + {1'b0, addend};
        end
    end

    assign last_step = (cnt == CW'(DW - 1));

endmodule

// File: rtl/root_square_check.sv
// ----------------------------------------------------------------------------
// root_square_check
// Sequential checker for square-root results: rebuilds root*root + reminder
// with a shift-add squarer and compares it with the original operand x.
//   clk  : system clock, rising edge
//   rst  : synchronous, active-high reset (aborts any run, clears outputs)
//   bus  : root_square_check_if.slave (request operands, result outputs)
// Timing: start accepted at edge N -> o_done high after edge N+DW+2.
// Optional build macro ROOT_CHECK_BOUND_EN: flags reminder > 2*root as
// o_bound_err and withholds o_match in that case.
// ----------------------------------------------------------------------------
module root_square_check
    import root_square_check_pkg::*;
#(
    parameter int unsigned DW = MDR_DW
) (
    input  logic                clk,
    input  logic                rst,
    root_square_check_if.slave  bus
);

    root_chk_state_t state, state_nxt;

    logic            load, step, add_rem, capture, busy;
    logic            last_step;
    logic [2*DW:0]   acc;
    logic [DW-1:0]   x_q;
    logic [2*DW-1:0] rem_q;

    logic            done_q, match_q, ovf_q, bnd_q;
    logic [2*DW-1:0] value_q;
    logic            eq_now, bnd_now;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.i_start) state_nxt = MUL;
            MUL:     if (last_step)   state_nxt = ADD;
            ADD:     state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // Busy spans the result strobe too, so it falls together with o_done.
    always_comb begin
        load    = (state == IDLE) && bus.i_start;
        step    = (state == MUL);
        add_rem = (state == ADD);
        capture = (state == DONE);
        busy    = (state != IDLE) || done_q;
    end

    // ---------------- operand capture ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            x_q   <= '0;
            rem_q <= '0;
        end else if (load) begin
            x_q   <= bus.i_val_x;
            rem_q <= bus.i_reminder;
        end
    end

    root_square_check_seq_squarer #(
        .DW (DW)
    ) u_seq_squarer (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .step      (step),
        .add_rem   (add_rem),
        .root      (bus.i_root),
        .addend    (rem_q),
        .acc       (acc),
        .last_step (last_step)
    );

    // ---------------- reminder bound ----------------
`ifdef ROOT_CHECK_BOUND_EN
    logic [DW-1:0] root_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            root_q <= '0;
        end else if (load) begin
            root_q <= bus.i_root;
        end
    end

    // 2*root is a DW+1 bit quantity, zero-extended for the compare.
    assign bnd_now = (rem_q > {{(DW-1){1'b0}}, root_q, 1'b0});
`else
    assign bnd_now = 1'b0;
`endif

    assign eq_now = (acc[2*DW-1:0] == {{DW{1'b0}}, x_q});

    // ---------------- result registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            done_q  <= 1'b0;
            value_q <= '0;
            match_q <= 1'b0;
            ovf_q   <= 1'b0;
            bnd_q   <= 1'b0;
        end else begin
            done_q <= capture;
            if (capture) begin
                value_q <= acc[2*DW-1:0];
                ovf_q   <= acc[2*DW];
                bnd_q   <= bnd_now;
                match_q <= eq_now && !acc[2*DW] && !bnd_now;
            end
        end
    end

    assign bus.o_busy      = busy;
    assign bus.o_done      = done_q;
    assign bus.o_value     = value_q;
    assign bus.o_match     = match_q;
    assign bus.o_overflow  = ovf_q;
    assign bus.o_bound_err = bnd_q;

endmodule

// File: tb/tb_root_square_check.sv
module tb_root_square_check;
    import root_square_check_pkg::*;

`ifdef ROOT_CHECK_BOUND_EN
    localparam bit BOUND_EN = 1'b1;
`else
    localparam bit BOUND_EN = 1'b0;
`endif

    typedef struct {
        data_in_t root;
        data_t    rem;
        data_in_t x;
        data_t    value;
        bit       eq_ok;   // match expected when no bound checking applies
        bit       ovf;
        bit       bnd;     // reminder > 2*root
    } vec_t;

    typedef struct {
        data_t       value;
        bit          match;
        bit          ovf;
        bit          bnd;
        int unsigned done_edge;
    } exp_t;

    logic clk;
    logic rst;
    int unsigned edge_cnt = 0;
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    exp_t sb[$];

    root_square_check_if #(.DW(MDR_DW)) bus ();

    root_square_check #(.DW(MDR_DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    function automatic exp_t from_vec(input vec_t v);
        exp_t e;
        e.value     = v.value;
        e.ovf       = v.ovf;
        e.bnd       = BOUND_EN && v.bnd;
        e.match     = v.eq_ok && !e.bnd;
        e.done_edge = 0;
        return e;
    endfunction

    function automatic exp_t model(input data_in_t r, input data_t m, input data_in_t x);
        exp_t e;
        logic [32:0] v;
        v = 33'(r) * 33'(r) + 33'(m);
        e.value     = v[31:0];
        e.ovf       = v[32];
        e.bnd       = BOUND_EN && (m > 32'(r) * 2);
        e.match     = (v[31:0] == 32'(x)) && !e.ovf && !e.bnd;
        e.done_edge = 0;
        return e;
    endfunction

    // Monitor / scoreboard
    bit    prev_done = 1'b0;
    data_t last_value = '0;
    always @(negedge clk) begin
        exp_t e;
        if (prev_done) begin
            chk("done_single_cycle", bus.o_done, 0);
            chk("value_hold", bus.o_value, last_value);
        end
        if (bus.o_done === 1'b1) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got o_done=1 at edge %0d, required no result", edge_cnt);
            end else begin
                e = sb.pop_front();
                chk("o_value",     bus.o_value,     e.value);
                chk("o_match",     bus.o_match,     e.match);
                chk("o_overflow",  bus.o_overflow,  e.ovf);
                chk("o_bound_err", bus.o_bound_err, e.bnd);
                chk("done_edge",   edge_cnt,        e.done_edge);
            end
            last_value = bus.o_value;
        end
        prev_done = (bus.o_done === 1'b1);
    end

    // Called away from a rising edge; the request is sampled at the next edge.
    task automatic start_op(input data_in_t r, input data_t m, input data_in_t x,
                            input bit track, input exp_t e);
        exp_t ee;
        bus.i_root     = r;
        bus.i_reminder = m;
        bus.i_val_x    = x;
        bus.i_start    = 1'b1;
        @(posedge clk);
        #1;
        bus.i_start  = 1'b0;
        ee           = e;
        ee.done_edge = edge_cnt + 18;
        if (track) sb.push_back(ee);
        chk("busy_after_start", bus.o_busy, 1);
    endtask

    task automatic wait_done(input string tag);
        int unsigned n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: got %0d results outstanding, required 0", tag, sb.size());
            sb.delete();
        end
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_busy"},  bus.o_busy,      0);
        chk({tag, "_done"},  bus.o_done,      0);
        chk({tag, "_value"}, bus.o_value,     0);
        chk({tag, "_match"}, bus.o_match,     0);
        chk({tag, "_ovf"},   bus.o_overflow,  0);
        chk({tag, "_bnd"},   bus.o_bound_err, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[13];
        exp_t e;
        data_in_t r, x;
        data_t    m;

        //           root        rem            x            value          eq ovf bnd
        tbl[0]  = '{16'd12,     32'd0,         16'd144,     32'd144,        1, 0, 0};
        tbl[1]  = '{16'd12,     32'd6,         16'd150,     32'd150,        1, 0, 0};
        tbl[2]  = '{16'd12,     32'd7,         16'd150,     32'd151,        0, 0, 0};
        tbl[3]  = '{16'd255,    32'd510,       16'd65535,   32'd65535,      1, 0, 0};
        tbl[4]  = '{16'd12,     32'd600,       16'd744,     32'd744,        1, 0, 1};
        tbl[5]  = '{16'hFFFF,   32'hFFFF_FFFF, 16'd0,       32'hFFFE_0000,  0, 1, 1};
        tbl[6]  = '{16'd0,      32'd5,         16'd5,       32'd5,          1, 0, 1};
        tbl[7]  = '{16'd0,      32'd0,         16'd0,       32'd0,          1, 0, 0};
        tbl[8]  = '{16'hFFFF,   32'h0001_FFFE, 16'hFFFF,    32'hFFFF_FFFF,  0, 0, 0};
        tbl[9]  = '{16'hFFFF,   32'h0001_FFFF, 16'd0,       32'h0000_0000,  0, 1, 1};
        tbl[10] = '{16'd1,      32'd0,         16'd1,       32'd1,          1, 0, 0};
        tbl[11] = '{16'd256,    32'd0,         16'd0,       32'h0001_0000,  0, 0, 0};
        tbl[12] = '{16'h8000,   32'h0001_0000, 16'd0,       32'h4001_0000,  0, 0, 0};

        rst            = 1'b1;
        bus.i_start    = 1'b0;
        bus.i_root     = '0;
        bus.i_reminder = '0;
        bus.i_val_x    = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_outputs_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // Table vectors, issued back-to-back as soon as each result appears
        foreach (tbl[i]) begin
            start_op(tbl[i].root, tbl[i].rem, tbl[i].x, 1'b1, from_vec(tbl[i]));
            wait_done("table");
        end

        // Random small roots checked against the arithmetic model
        for (int k = 0; k < 6; k++) begin
            r = 16'($urandom_range(0, 255));
            m = 32'($urandom_range(0, 2 * int'(r) + 3));
            x = 16'(32'(r) * 32'(r) + m);
            start_op(r, m, x, 1'b1, model(r, m, x));
            wait_done("random");
        end

        // Start pulse during a run is ignored; next start the cycle after done
        start_op(16'd12, 32'd0, 16'd144, 1'b1, model(16'd12, 32'd0, 16'd144));
        repeat (4) @(posedge clk);
        #1;
        bus.i_root     = 16'd7;
        bus.i_reminder = 32'd1;
        bus.i_val_x    = 16'd50;
        bus.i_start    = 1'b1;
        @(posedge clk);
        #1;
        bus.i_start = 1'b0;
        chk("busy_during_ignored_start", bus.o_busy, 1);
        wait_done("ignored_start");
        start_op(16'd200, 32'd3, 16'd40003, 1'b1, model(16'd200, 32'd3, 16'd40003));
        wait_done("after_ignored");

        // Reset in the middle of a run: immediate abort, no result
        start_op(16'd100, 32'd0, 16'd10000, 1'b0, model(16'd100, 32'd0, 16'd10000));
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk_outputs_zero("abort");
        rst = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        chk("abort_stays_idle", bus.o_busy, 0);
        start_op(16'd300, 32'd17, 16'd24497, 1'b1, model(16'd300, 32'd17, 16'd24497));
        wait_done("after_abort");
        repeat (3) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
